// File: rtl/seg7_multidigit_driver.sv
// Multi-digit active-low seven-segment driver.
// Shows a WIDTH-bit value on NDIGITS displays in hex or in decimal. Decimal
// digits come from an iterative double-dabble conversion, one input bit per
// cycle. Also provides leading-zero blanking, an overflow indication (all
// dashes) and whole-display blinking.
module seg7_multidigit_driver #(
  parameter int WIDTH     = 16,
  parameter int NDIGITS   = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                   i_clock,
  input  logic                   i_resetn,
  input  logic                   i_load,
  input  logic [WIDTH-1:0]       i_value,
  input  logic                   i_decimal,
  input  logic                   i_blank_zeros,
  input  logic                   i_blink,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overflow,
  output logic [7*NDIGITS-1:0]   o_hex
);

  localparam int BCDW = 4 * NDIGITS;
  localparam int HEXW = 7 * NDIGITS;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int BLW  = $clog2(BLINK_DIV);

  localparam logic [CNTW-1:0] CNT_LOAD   = CNTW'(WIDTH);
  localparam logic [CNTW-1:0] CNT_LAST   = CNTW'(1);
  localparam logic [BLW-1:0]  BLINK_LAST = BLW'(BLINK_DIV - 1);

  // Glyphs in bus order: bit i = segment i (bit 0 = a, bit 6 = g), 0 = lit.
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_UPDATE
  } state_t;

  // Reverse a glyph written in a..g reading order into bus order.
  function automatic logic [6:0] abcdefg_to_bus(input logic [6:0] abcdefg);
    logic [6:0] bus;
    for (int i = 0; i < 7; i++) begin
      bus[i] = abcdefg[6-i];
    end
    return bus;
  endfunction

  // Hex glyph lookup; literals are written a..g so they read like a datasheet.
  function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
    logic [6:0] abcdefg;
    case (digit)
      4'h0:    abcdefg = 7'b0000001;
      4'h1:    abcdefg = 7'b1001111;
      4'h2:    abcdefg = 7'b0010010;
      4'h3:    abcdefg = 7'b0000110;
      4'h4:    abcdefg = 7'b1001100;
      4'h5:    abcdefg = 7'b0100100;
      4'h6:    abcdefg = 7'b0100000;
      4'h7:    abcdefg = 7'b0001111;
      4'h8:    abcdefg = 7'b0000000;
      4'h9:    abcdefg = 7'b0001100;
      4'hA:    abcdefg = 7'b0001000;
      4'hB:    abcdefg = 7'b1100000;
      4'hC:    abcdefg = 7'b0110001;
      4'hD:    abcdefg = 7'b1000010;
      4'hE:    abcdefg = 7'b0110000;
      default: abcdefg = 7'b0111000;
    endcase
    return abcdefg_to_bus(abcdefg);
  endfunction

  state_t            r_state;
  state_t            w_state_next;
  logic              w_busy;
  logic              w_capture;
  logic              w_update;

  logic [BCDW-1:0]   r_bcd;
  logic [WIDTH-1:0]  r_shift;
  logic [CNTW-1:0]   r_cnt;
  logic              r_ovf_sticky;
  logic              r_blank_zeros;

  logic [HEXW-1:0]   r_pattern;
  logic              r_overflow;
  logic              r_done;

  logic [BLW-1:0]    r_blink_cnt;
  logic              r_phase_on;

  logic [BCDW-1:0]   w_hex_digits;
  logic              w_hex_ovf;
  logic [BCDW-1:0]   w_bcd_adj;
  logic [NDIGITS-1:0] w_blank_mask;
  logic [HEXW-1:0]   w_pattern_new;

  // Hex mode digits: the value's nibbles, zero-extended to the display width.
  generate
    for (genvar gi = 0; gi < BCDW; gi++) begin : g_hex_bits
      if (gi < WIDTH) begin : g_src
        assign w_hex_digits[gi] = i_value[gi];
      end else begin : g_pad
        assign w_hex_digits[gi] = 1'b0;
      end
    end
    if (WIDTH > BCDW) begin : g_hex_ovf
      assign w_hex_ovf = |i_value[WIDTH-1:BCDW];
    end else begin : g_hex_no_ovf
      assign w_hex_ovf = 1'b0;
    end
  endgenerate

  // Double-dabble correction: every BCD digit of 5 or more gets 3 added.
  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_adj
      assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                    (r_bcd[4*gi +: 4] + 4'd3) : r_bcd[4*gi +: 4];
    end
  endgenerate

  // State register.
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and control strobes.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_capture    = 1'b0;
    w_update     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_load) begin
          w_capture    = 1'b1;
          w_state_next = i_decimal ? S_CONVERT : S_UPDATE;
        end
      end
      S_CONVERT: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_busy       = 1'b1;
        w_update     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Capture a request and run the bit-serial binary-to-BCD conversion.
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_bcd         <= '0;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_ovf_sticky  <= 1'b0;
      r_blank_zeros <= 1'b0;
    end else if (w_capture) begin
      r_blank_zeros <= i_blank_zeros;
      if (i_decimal) begin
        r_bcd        <= '0;
        r_shift      <= i_value;
        r_cnt        <= CNT_LOAD;
        r_ovf_sticky <= 1'b0;
      end else begin
        r_bcd        <= w_hex_digits;
        r_ovf_sticky <= w_hex_ovf;
      end
    end else if (r_state == S_CONVERT) begin
      // A set top bit after correction would be shifted out: too many digits.
      if (w_bcd_adj[BCDW-1]) begin
        r_ovf_sticky <= 1'b1;
      end
      r_bcd   <= {w_bcd_adj[BCDW-2:0], r_shift[WIDTH-1]};
      r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      r_cnt   <= r_cnt - CNT_LAST;
    end
  end

  // Leading-zero mask: a digit blanks when it and all digits above are zero.
  always_comb begin
    logic zero_run;
    w_blank_mask = '0;
    zero_run     = 1'b1;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      zero_run        = zero_run && (r_bcd[4*k +: 4] == 4'd0);
      w_blank_mask[k] = r_blank_zeros && zero_run && (k != 0);
    end
  end

  // Per-digit glyph selection for the pattern about to be committed.
  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_glyph
      assign w_pattern_new[7*gi +: 7] = r_ovf_sticky      ? GLYPH_DASH  :
                                        w_blank_mask[gi]  ? GLYPH_BLANK :
                                        seg_glyph(r_bcd[4*gi +: 4]);
    end
  endgenerate

  // Commit the pattern and overflow flag, and pulse Done, in UPDATE.
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_pattern  <= '1;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_update;
      if (w_update) begin
        r_pattern  <= w_pattern_new;
        r_overflow <= r_ovf_sticky;
      end
    end
  end

  // Free-running blink divider; phase flips each time the counter wraps.
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_blink_cnt <= '0;
      r_phase_on  <= 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_phase_on  <= ~r_phase_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLW'(1);
    end
  end

  assign o_hex      = (i_blink && !r_phase_on) ? '1 : r_pattern;
  assign o_busy     = w_busy;
  assign o_done     = r_done;
  assign o_overflow = r_overflow;

endmodule

// File: doc/seg7_multidigit_driver.md
Name: seg7_multidigit_driver

Overview:
- Parametrised successor to the single-digit 4-bit hex-to-7-segment decoder.
- Drives NDIGITS active-low seven-segment digits (DE1 HEX displays) from a WIDTH-bit value.
- Supports hex or decimal display, where decimal uses iterative double-dabble binary-to-BCD conversion.
- Adds leading-zero blanking, overflow indication and blinking, and sits between datapath registers and the board HEX pins.

Parameters:
- WIDTH, 16, bit width of the input value (>=4).
- NDIGITS, 4, number of displayed digits (1..8).
- BLINK_DIV, 25000000, clock cycles per blink half-period (>=2).

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Resetn  input  1  synchronous, active-low reset.
- Load  input  1  request to capture Value/Decimal/BlankZeros; honoured only in IDLE.
- Value  input  WIDTH  unsigned value to display.
- Decimal  input  1  1 = decimal display, 0 = hex display.
- BlankZeros  input  1  1 = blank leading zero digits.
- Blink  input  1  1 = flash the whole display at the BLINK_DIV rate.
- Busy  output  1  high while a captured request is being processed.
- Done  output  1  one-cycle pulse when the new pattern is committed.
- Overflow  output  1  the last committed value did not fit in NDIGITS digits.
- HEX  output  7*NDIGITS  segment bus; digit k (k=0 is least significant) at bits 7k..7k+6; bit 7k+i = segment i (0=a … 6=g); 0 = segment lit.

Behaviour:
- Glyphs, as a..g, active-low:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0001100
  - A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000
  - blank = 1111111, dash = 1111110
- Reset (Resetn=0 at an edge, from any state):
  - state IDLE; pattern register all blank; Busy=0; Done=0; Overflow=0.
  - BCD/shift registers 0; blink counter 0; blink phase = on.
  - A conversion in progress is aborted and discarded.
- FSM states: IDLE, CONVERT, UPDATE.
- IDLE:
  - Load=1 at an edge captures Value, Decimal and BlankZeros.
  - Decimal=0: next state UPDATE. Digits are the nibbles of Value, zero-extended. Overflow candidate = any Value bit at index >= 4*NDIGITS is set.
  - Decimal=1: next state CONVERT. BCD register (4*NDIGITS bits) = 0; bit counter = WIDTH; sticky overflow = 0.
- CONVERT, one input bit per cycle, MSB first:
  - Add 3 to every BCD digit >= 5.
  - If the top BCD bit is then 1, set sticky overflow.
  - Shift {BCD, value} left by 1 and decrement the counter.
  - Leave for UPDATE after exactly WIDTH cycles.
- UPDATE (one cycle):
  - Commit the pattern register and Overflow; pulse Done=1 for exactly one cycle; return to IDLE.
  - Overflow=1: every digit shows dash.
  - Else, BlankZeros=1: digits above the most significant non-zero digit are blank. Digit 0 is always shown, so value 0 displays "0".
  - Else: all digits shown.
- Busy is 1 in CONVERT and UPDATE, 0 in IDLE.
- Latency from the edge that samples Load:
  - Hex mode: Done and the new pattern appear after edge 2; Busy high 1 cycle.
  - Decimal mode: Done and the new pattern appear after edge WIDTH+2; Busy high WIDTH+1 cycles.
- Load while Busy=1 is ignored (not queued). Load in the cycle Done=1 is accepted, since the FSM is already in IDLE.
- Overflow and the pattern hold until the next commit.
- Blink:
  - The counter runs freely from reset, wrapping at BLINK_DIV-1; phase toggles on each wrap.
  - HEX = all blank when Blink=1 and phase=off; otherwise HEX = pattern register.
  - This output mux is combinational on the registered phase and the Blink input.
  - Blink never affects Busy, Done or the stored pattern.

Test Plan (WIDTH=16, NDIGITS=4, BLINK_DIV=4):
- Resetn=0 for 3 edges with Load=1 -> HEX=28'hFFFFFFF, Busy=0, Done=0, Overflow=0 throughout.
- Hex, Value=16'h1A3F, BlankZeros=0 -> after edge 2: digits 3..0 = 1001111, 0001000, 0000110, 0111000; Done high one cycle; Busy high one cycle.
- Decimal, Value=1234 -> Busy high 17 cycles; Load pulses during Busy ignored; after edge 18: digits 1,2,3,4, Overflow=0. Repeat with 9999 (Overflow=0) and 65535 (Overflow=1, all digits 1111110).
- Decimal with BlankZeros=1:
  - Value=42 -> digits 3,2 blank, digit 1 = 1001100, digit 0 = 0010010.
  - Value=0 -> digits 3..1 blank, digit 0 = 0000001.
- Blink=1 with pattern "0000" -> HEX alternates pattern/blank every 4 cycles; Blink=0 -> pattern steady immediately.
- Decimal Load of 1234, then Resetn=0 at conversion edge 5 -> after that edge Busy=0, HEX blank, no Done pulse; next Load of 56 completes normally showing 0056.
